// File: rtl/fifo_rr_sched_pkg.sv
// fifo_sched_pkg: shared scheduler state encoding and queue-id width helper.
package fifo_sched_pkg;

    typedef enum logic {IDLE, SERVE} state_t;

    function automatic int qid_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_rr_sched_rr_pick.sv
// rr_pick: combinational cyclic priority search starting at i_ptr.
module rr_pick
    import fifo_sched_pkg::*;
#(
    parameter int NQ = 4,
    parameter int QW = qid_w(NQ)
) (
    input  logic [NQ-1:0] i_req,
    input  logic [QW-1:0] i_ptr,
    output logic [QW-1:0] o_gnt_idx,
    output logic          o_gnt_any
);

    logic [QW-1:0] w_idx;

    // Scan farthest-first so the request closest to i_ptr is written last and wins.
    always_comb begin
        o_gnt_idx = '0;
        w_idx     = '0;
        o_gnt_any = |i_req;
        for (int k = NQ - 1; k >= 0; k--) begin
            w_idx = QW'((int'(i_ptr) + k) % NQ);
            if (i_req[w_idx]) o_gnt_idx = w_idx;
        end
    end

endmodule

// File: rtl/fifo_rr_sched.sv
// fifo_rr_sched: round-robin burst drain of NQ peek-mode FIFOs into one
// registered output stage with ready/valid backpressure.
module fifo_rr_sched
    import fifo_sched_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NQ    = 4,
    parameter int BURST = 4,
    localparam int QW   = qid_w(NQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NQ-1:0]       i_q_empty,
    input  logic [NQ*WIDTH-1:0] i_q_rdata,
    output logic [NQ-1:0]       o_q_pop,
    input  logic                i_flush,
    output logic                o_out_valid,
    output logic [WIDTH-1:0]    o_out_data,
    output logic [QW-1:0]       o_out_qid,
    input  logic                i_out_ready,
    output logic                o_busy
);

    state_t           r_state;
    logic [QW-1:0]    r_cur_q;
    logic [QW-1:0]    r_rr_ptr;
    logic [7:0]       r_cnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [QW-1:0]    r_out_qid;

    logic             w_adv;
    logic             w_any;
    logic [QW-1:0]    w_sel;
    logic             w_cur_ne;
    logic             w_pop;
    logic [QW-1:0]    w_pop_q;
    logic [WIDTH-1:0] w_word;
    logic             w_last;
    logic [QW-1:0]    w_sel_nxt;
    logic [QW-1:0]    w_cur_nxt;

    rr_pick #(.NQ(NQ), .QW(QW)) u_pick (
        .i_req     (~i_q_empty),
        .i_ptr     (r_rr_ptr),
        .o_gnt_idx (w_sel),
        .o_gnt_any (w_any)
    );

    assign w_adv     = (!r_out_valid || i_out_ready) && !i_flush;
    assign w_cur_ne  = !i_q_empty[r_cur_q];
    assign w_pop     = rst_n && w_adv && ((r_state == IDLE) ? w_any : w_cur_ne);
    assign w_pop_q   = (r_state == IDLE) ? w_sel : r_cur_q;
    assign w_last    = ({1'b0, r_cnt} + 9'd1) == 9'(BURST);
    assign w_sel_nxt = (w_sel == QW'(NQ - 1)) ? '0 : w_sel + 1'b1;
    assign w_cur_nxt = (r_cur_q == QW'(NQ - 1)) ? '0 : r_cur_q + 1'b1;

    always_comb begin
        w_word  = '0;
        o_q_pop = '0;
        for (int k = 0; k < NQ; k++) begin
            if (QW'(k) == w_pop_q) w_word = i_q_rdata[k*WIDTH +: WIDTH];
            o_q_pop[k] = w_pop && (QW'(k) == w_pop_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cur_q     <= '0;
            r_rr_ptr    <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_qid   <= '0;
        end else if (i_flush) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_pop) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_word;
                r_out_qid   <= w_pop_q;
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (r_state == IDLE) begin
                if (w_pop) begin
                    r_cur_q <= w_sel;
                    r_cnt   <= 8'd1;
                    if (BURST == 1) r_rr_ptr <= w_sel_nxt;
                    else r_state <= SERVE;
                end
            end else if (w_adv) begin
                if (w_pop) r_cnt <= r_cnt + 8'd1;
                // Burst ends on reaching BURST or on the first empty head (bubble cycle).
                if (!w_pop || w_last) begin
                    r_state  <= IDLE;
                    r_rr_ptr <= w_cur_nxt;
                end
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_qid   = r_out_qid;
    assign o_busy      = (r_state == SERVE) || r_out_valid;

endmodule

// File: tb/tb_fifo_rr_sched.sv
// tb_fifo_rr_sched: table-driven drain scenarios plus hand-written backpressure,
// flush and reset sequences, checked against a queue of expected output words.
module tb_fifo_rr_sched;

    localparam int NQ = 4;
    localparam int W  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NQ-1:0] q_empty;
    logic [NQ*W-1:0] q_rdata;
    logic [NQ-1:0] q_pop;
    logic          flush = 1'b0;
    logic          ready = 1'b1;
    logic          ov;
    logic [W-1:0]  od;
    logic [1:0]    oq;
    logic          busy;

    always #5 clk = ~clk;

    fifo_rr_sched #(.WIDTH(W), .NQ(NQ), .BURST(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_q_empty   (q_empty),
        .i_q_rdata   (q_rdata),
        .o_q_pop     (q_pop),
        .i_flush     (flush),
        .o_out_valid (ov),
        .o_out_data  (od),
        .o_out_qid   (oq),
        .i_out_ready (ready),
        .o_busy      (busy)
    );

    typedef struct {
        logic [1:0]  q;
        logic [15:0] d;
    } exp_t;

    typedef struct {
        int n[4];
        int len;
        int q[8];
        int gaps;
    } row_t;

    logic [15:0] bq[NQ][$];
    exp_t        sb[$];
    row_t        rows[4];
    int          checks = 0;
    int          failures = 0;
    int          seen, gaps, pend;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < NQ; k++) begin
            q_empty[k] = (bq[k].size() == 0);
            q_rdata[k*W +: W] = (bq[k].size() == 0) ? 16'h0 : bq[k][0];
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int k = 0; k < NQ; k++) s += bq[k].size();
        return s;
    endfunction

    task automatic load(input int q, input int n);
        for (int i = 0; i < n; i++) bq[q].push_back(16'(q * 256 + i));
    endtask

    task automatic expect_word(input int q, input int i);
        exp_t e;
        e.q = 2'(q);
        e.d = 16'(q * 256 + i);
        sb.push_back(e);
    endtask

    // One clock: check pop legality and consumed output, then retire popped words.
    task automatic cyc();
        logic [NQ-1:0] p;
        exp_t e;
        drive();
        #1;
        chk("pop_onehot", 32'($onehot0(q_pop)), 1);
        for (int k = 0; k < NQ; k++)
            if (q_pop[k]) chk("pop_nonempty", 32'(bq[k].size() != 0), 1);
        if (flush) chk("pop_during_flush", 32'(q_pop), 0);
        if (ov && ready) begin
            if (sb.size() == 0) chk("unexpected_word", 32'(ov), 0);
            else begin
                e = sb.pop_front();
                chk("out_qid", 32'(oq), 32'(e.q));
                chk("out_data", 32'(od), 32'(e.d));
            end
        end
        if (ov) begin
            if (seen != 0) gaps += pend;
            pend = 0;
            seen = 1;
        end else if (seen != 0) pend++;
        p = q_pop;
        @(posedge clk);
        for (int k = 0; k < NQ; k++)
            if (p[k] && bq[k].size() > 0) void'(bq[k].pop_front());
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((sb.size() > 0 || pending() > 0) && n < budget) begin
            cyc();
            n++;
        end
        repeat (3) cyc();
        chk("drain_done", 32'(sb.size()), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        ready = 1'b1;
        for (int k = 0; k < NQ; k++) bq[k].delete();
        sb.delete();
        seen = 0;
        gaps = 0;
        pend = 0;
        repeat (2) @(negedge clk);
        drive();
        #1;
        chk("rst_valid", 32'(ov), 0);
        chk("rst_data", 32'(od), 0);
        chk("rst_qid", 32'(oq), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int kk[4];
        rows[0] = '{n: '{6, 2, 0, 0}, len: 8, q: '{0, 0, 0, 0, 1, 1, 0, 0}, gaps: 1};
        rows[1] = '{n: '{1, 1, 1, 1}, len: 4, q: '{0, 1, 2, 3, 0, 0, 0, 0}, gaps: 3};
        rows[2] = '{n: '{0, 0, 3, 1}, len: 4, q: '{2, 2, 2, 3, 0, 0, 0, 0}, gaps: 1};
        rows[3] = '{n: '{0, 5, 0, 2}, len: 7, q: '{1, 1, 1, 1, 3, 3, 1, 0}, gaps: 1};

        // Idle with all queues empty.
        do_reset();
        repeat (10) begin
            drive();
            #1;
            chk("idle_pop", 32'(q_pop), 0);
            chk("idle_valid", 32'(ov), 0);
            chk("idle_busy", 32'(busy), 0);
            cyc();
        end

        for (int r = 0; r < 4; r++) begin
            do_reset();
            kk = '{0, 0, 0, 0};
            for (int q = 0; q < NQ; q++) load(q, rows[r].n[q]);
            for (int i = 0; i < rows[r].len; i++) begin
                expect_word(rows[r].q[i], kk[rows[r].q[i]]);
                kk[rows[r].q[i]]++;
            end
            drain(60);
            chk("bubble_gaps", 32'(gaps), 32'(rows[r].gaps));
            chk("queues_drained", 32'(pending()), 0);
        end

        // Backpressure: output word held while stalled, pop resumes with ready.
        do_reset();
        load(0, 3);
        for (int i = 0; i < 3; i++) expect_word(0, i);
        ready = 1'b0;
        cyc();
        repeat (3) begin
            drive();
            #1;
            chk("stall_valid", 32'(ov), 1);
            chk("stall_data", 32'(od), 32'h0000);
            chk("stall_qid", 32'(oq), 0);
            chk("stall_pop", 32'(q_pop), 0);
            cyc();
        end
        ready = 1'b1;
        drive();
        #1;
        chk("resume_pop", 32'(q_pop), 32'b0001);
        drain(40);

        // Flush on the second pop of a Q2 burst drops the staged word.
        do_reset();
        load(2, 4);
        load(3, 1);
        cyc();
        ready = 1'b0;
        flush = 1'b1;
        drive();
        #1;
        chk("flush_pop", 32'(q_pop), 0);
        cyc();
        flush = 1'b0;
        ready = 1'b1;
        chk("flush_valid", 32'(ov), 0);
        chk("flush_busy", 32'(busy), 0);
        drive();
        #1;
        chk("flush_regrant", 32'(q_pop), 32'b0100);
        for (int i = 1; i < 4; i++) expect_word(2, i);
        expect_word(3, 0);
        drain(40);

        // Asynchronous reset in the middle of a Q3 burst.
        do_reset();
        load(3, 4);
        expect_word(3, 0);
        cyc();
        cyc();
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ov), 0);
        chk("arst_data", 32'(od), 0);
        chk("arst_qid", 32'(oq), 0);
        chk("arst_pop", 32'(q_pop), 0);
        chk("arst_busy", 32'(busy), 0);
        sb.delete();
        load(0, 1);
        expect_word(0, 0);
        expect_word(3, 2);
        expect_word(3, 3);
        @(negedge clk);
        rst_n = 1'b1;
        drive();
        #1;
        chk("post_reset_grant", 32'(q_pop), 32'b0001);
        drain(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_rr_sched.md
FIFO_RR_SCHED -- requirements
Module: fifo_rr_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width of every queue word.
REQ-002 SHALL have parameter NQ, default 4, number of drained queues (2..16).
REQ-003 SHALL have parameter BURST, default 4, maximum consecutive pops per grant (1..255).
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 q_empty  input  NQ  per-queue empty flag from peek-mode FIFOs.
REQ-007 q_rdata  input  NQ x WIDTH  per-queue head word, valid when q_empty[i]=0.
REQ-008 q_pop  output  NQ  per-queue pop strobe, at most one bit high per cycle.
REQ-009 flush  input  1  synchronous abort of scheduler state and output stage.
REQ-010 out_valid  output  1  output word valid.
REQ-011 out_data  output  WIDTH  output word.
REQ-012 out_qid  output  clog2(NQ)  source queue of out_data.
REQ-013 out_ready  input  1  downstream accepts word when out_valid=1 and out_ready=1.
REQ-014 busy  output  1  high when state=SERVE or out_valid=1.

Function
REQ-015 SHALL define advance = (out_valid=0 or out_ready=1) and flush=0.
REQ-016 SHALL use states IDLE and SERVE, with registers cur_q, cnt (8 bit), rr_ptr.
REQ-017 IDLE: if advance and any q_empty[i]=0, SHALL select the first non-empty queue searching cyclically from rr_ptr, pop it the same cycle, load cur_q=sel, cnt=1.
REQ-018 IDLE pop with BURST=1 SHALL stay IDLE and set rr_ptr=(sel+1) mod NQ; otherwise SHALL go to SERVE.
REQ-019 SERVE, advance, q_empty[cur_q]=0: SHALL pop cur_q, cnt+1; if cnt+1=BURST, SHALL go IDLE, rr_ptr=(cur_q+1) mod NQ.
REQ-020 SERVE, advance, q_empty[cur_q]=1: SHALL not pop, go IDLE, rr_ptr=(cur_q+1) mod NQ (one bubble cycle).
REQ-021 SERVE or IDLE with advance=0: SHALL hold all state, q_pop=0.
REQ-022 Pop in cycle t SHALL register q_rdata[popped], qid into out_data/out_qid with out_valid=1 at t+1 (latency 1).
REQ-023 No pop and out_ready=1 SHALL clear out_valid; out_data/out_qid hold while out_valid=1 and out_ready=0.
REQ-024 q_pop SHALL be combinational, never asserted for an empty queue, never while flush=1.
REQ-025 flush=1 SHALL, next cycle: out_valid=0, state=IDLE, cnt=0; rr_ptr preserved; the word in the output stage is dropped.
REQ-026 Queues empty throughout SHALL leave state IDLE, outputs idle, rr_ptr unchanged.
REQ-027 rr_ptr SHALL wrap NQ-1 -> 0; cnt SHALL never exceed BURST.

Reset
REQ-028 rst_n=0 SHALL immediately force: state=IDLE, cnt=0, cur_q=0, rr_ptr=0, out_valid=0, out_data=0, out_qid=0, q_pop=0, busy=0.
REQ-029 Reset mid-burst SHALL abandon the burst; first grant after release starts search at queue 0.

Structure
REQ-030 Package fifo_sched_pkg SHALL hold the state enum (IDLE, SERVE) and the qid-width function/constant.
REQ-031 Cyclic priority search SHALL be a sub-module rr_pick (inputs req[NQ], ptr; outputs gnt_idx, gnt_any), purely combinational.

Verification
REQ-032 Reset, all q_empty=1, out_ready=1 for 10 cycles -> q_pop=0, out_valid=0, busy=0 throughout.
REQ-033 BURST=4, Q0 holds 6 words, Q1 holds 2, out_ready=1 -> out_qid sequence 0,0,0,0,1,1,0,0 with one bubble after Q1 drains.
REQ-034 All four queues hold 1 word, BURST=4 -> out_qid 0,1,2,3, each queue popped exactly once.
REQ-035 out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_qid stable, q_pop=0; pops resume the cycle out_ready=1.
REQ-036 flush=1 during 2nd pop of Q2 burst -> no pop that cycle, out_valid=0 next cycle, next grant searches from rr_ptr unchanged.
REQ-037 rst_n low mid-burst on Q3 -> outputs zero immediately; after release, Q0 and Q3 non-empty -> Q0 granted first.
